// File: rtl/reg_file_pkg.sv
// Shared constants and typedefs for the register file and its scoreboard.
// Default widths match the RV32 integer register file.
package reg_file_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;
    typedef logic [DEF_ADDR_W:0]   pend_cnt_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Register-file bus: write port, two read ports and issue/busy scoreboard.
// The pipeline drives through master, the register file sits on slave.
interface reg_file_sb_if
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              RegWrite;
    logic [ADDR_W-1:0] WN;
    logic [DATA_W-1:0] WD;
    logic [ADDR_W-1:0] RN1;
    logic [ADDR_W-1:0] RN2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              busy1;
    logic              busy2;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output RegWrite, WN, WD, RN1, RN2,
        output issue_valid, issue_rd,
        input  RD1, RD2, busy1, busy2, pend_cnt
    );

    modport slave (
        input  RegWrite, WN, WD, RN1, RN2,
        input  issue_valid, issue_rd,
        output RD1, RD2, busy1, busy2, pend_cnt
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-result flag per register index.
// Issue sets, write-back clears; a same-cycle issue beats the clear.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] wn,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rn1,
    input  logic [ADDR_W-1:0] rn2,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_hit;

    assign wr_hit = reg_write && (wn != '0);

    function automatic logic [ADDR_W:0] popcnt(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Next busy vector: clear on write-back, then set on issue.
    always_comb begin
        busy_d = busy_q;
        if (wr_hit) begin
            busy_d[wn] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Register busy bits and their population count together.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= '0;
            pend_cnt <= '0;
        end else begin
            busy_q   <= busy_d;
            pend_cnt <= popcnt(busy_d);
        end
    end

    // A result being written this cycle is no longer pending for readers.
    always_comb begin
        busy1 = busy_q[rn1];
        busy2 = busy_q[rn2];
        if (BYPASS && wr_hit && (wn == rn1)) begin
            busy1 = 1'b0;
        end
        if (BYPASS && wr_hit && (wn == rn2)) begin
            busy2 = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with x0 hardwired to zero,
// optional write-to-read bypass and a busy scoreboard.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_sb_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_en;

    assign wr_en = bus.RegWrite && (bus.WN != '0);

    // Storage update; reset clears every entry, index 0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[bus.WN] <= bus.WD;
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        bus.RD1 = mem[bus.RN1];
        bus.RD2 = mem[bus.RN2];
        if (BYPASS && wr_en && (bus.WN == bus.RN1)) begin
            bus.RD1 = bus.WD;
        end
        if (BYPASS && wr_en && (bus.WN == bus.RN2)) begin
            bus.RD2 = bus.WD;
        end
        if (bus.RN1 == '0) begin
            bus.RD1 = '0;
        end
        if (bus.RN2 == '0) begin
            bus.RD2 = '0;
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .reg_write   (bus.RegWrite),
        .wn          (bus.WN),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .rn1         (bus.RN1),
        .rn2         (bus.RN2),
        .busy1       (bus.busy1),
        .busy2       (bus.busy2),
        .pend_cnt    (bus.pend_cnt)
    );

endmodule
